// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared period counter and double-buffered duty.
// Duty changes land on period boundaries, either as a direct load or as a per-period ramp.
module pwm_multi_channel #(
    parameter int CNT_W     = 10,
    parameter int PERIOD    = 1000,
    parameter int NUM_CH    = 5,
    parameter int RAMP_STEP = 10,
    localparam int WR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_ramp_en,
    input  logic              i_wr_en,
    input  logic [WR_W-1:0]   i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_duty,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_period_start,
    output logic              o_settled
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(RAMP_STEP);
    localparam logic [CNT_W-1:0] STEP_N   = CNT_W'(RAMP_STEP);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tgt_q [NUM_CH];
    logic [CNT_W-1:0]  tgt_d [NUM_CH];
    logic [CNT_W-1:0]  act_q [NUM_CH];
    logic [CNT_W-1:0]  act_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              period_start_q, period_start_d;
    logic              boundary_s;
    logic              settled_s;

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] duty);
        if (duty > PERIOD_C) begin
            return PERIOD_C;
        end else begin
            return duty;
        end
    endfunction

    // Difference is taken one bit wider so act/tgt near full scale cannot wrap.
    function automatic logic [CNT_W-1:0] ramp_next(input logic [CNT_W-1:0] act,
                                                   input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] diff;
        if (tgt > act) begin
            diff = {1'b0, tgt} - {1'b0, act};
            if (diff > STEP_W) begin
                return act + STEP_N;
            end else begin
                return tgt;
            end
        end else if (act > tgt) begin
            diff = {1'b0, act} - {1'b0, tgt};
            if (diff > STEP_W) begin
                return act - STEP_N;
            end else begin
                return tgt;
            end
        end else begin
            return act;
        end
    endfunction

    // Next-state for counter, target/active duty and outputs.
    always_comb begin
        boundary_s = i_en && (cnt_q == LAST_C);

        if (!i_en) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (boundary_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        period_start_d = i_en && (cnt_q == {CNT_W{1'b0}});
        settled_s      = 1'b1;

        for (int n = 0; n < NUM_CH; n++) begin
            if (i_wr_en && (i_wr_ch == WR_W'(n))) begin
                tgt_d[n] = clamp_duty(i_wr_duty);
            end else begin
                tgt_d[n] = tgt_q[n];
            end

            // While idle without ramping, follow the freshest target so enable starts on it.
            if (!i_en) begin
                if (i_ramp_en) begin
                    act_d[n] = act_q[n];
                end else begin
                    act_d[n] = tgt_d[n];
                end
            end else if (boundary_s) begin
                if (i_ramp_en) begin
                    act_d[n] = ramp_next(act_q[n], tgt_q[n]);
                end else begin
                    act_d[n] = tgt_q[n];
                end
            end else begin
                act_d[n] = act_q[n];
            end

            pwm_d[n] = i_en && (cnt_q < act_q[n]);

            if (act_q[n] != tgt_q[n]) begin
                settled_s = 1'b0;
            end else begin
                settled_s = settled_s;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q          <= {CNT_W{1'b0}};
            pwm_q          <= {NUM_CH{1'b0}};
            period_start_q <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                tgt_q[n] <= {CNT_W{1'b0}};
                act_q[n] <= {CNT_W{1'b0}};
            end
        end else begin
            cnt_q          <= cnt_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            for (int n = 0; n < NUM_CH; n++) begin
                tgt_q[n] <= tgt_d[n];
                act_q[n] <= act_d[n];
            end
        end
    end

    assign o_pwm          = pwm_q;
    assign o_period_start = period_start_q;
    assign o_settled      = settled_s;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboarded bench for pwm_multi_channel: a per-period duty model predicts every output cycle.
module tb_pwm_multi_channel;

    localparam int CNT_W     = 10;
    localparam int PERIOD    = 1000;
    localparam int NUM_CH    = 5;
    localparam int RAMP_STEP = 10;
    localparam int WR_W      = 3;

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_en = 1'b0;
    logic              i_ramp_en = 1'b0;
    logic              i_wr_en = 1'b0;
    logic [WR_W-1:0]   i_wr_ch = 3'd0;
    logic [CNT_W-1:0]  i_wr_duty = 10'd0;
    logic [NUM_CH-1:0] o_pwm;
    logic              o_period_start;
    logic              o_settled;

    pwm_multi_channel #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .NUM_CH(NUM_CH), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_ramp_en(i_ramp_en),
        .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wr_duty(i_wr_duty),
        .o_pwm(o_pwm), .o_period_start(o_period_start), .o_settled(o_settled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] pwm;
        logic              ps;
        logic              settled;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: duty per channel for the current period, and offset within the period.
    int tgt_m[NUM_CH];
    int act_m[NUM_CH];
    int pos = 0;
    bit en_v = 1'b0;
    bit ramp_v = 1'b0;

    function automatic int ramp_toward(int a, int t);
        if (t - a > RAMP_STEP) return a + RAMP_STEP;
        if (a - t > RAMP_STEP) return a - RAMP_STEP;
        return t;
    endfunction

    task automatic model_step(bit rst, bit en, bit ramp, bit wr, int ch, int duty);
        exp_t e;
        e.pwm = '0;
        e.ps  = 1'b0;
        if (!rst && en) begin
            for (int n = 0; n < NUM_CH; n++) e.pwm[n] = (pos < act_m[n]);
            e.ps = (pos == 0);
        end
        if (rst) begin
            pos = 0;
            for (int n = 0; n < NUM_CH; n++) begin
                tgt_m[n] = 0;
                act_m[n] = 0;
            end
        end else begin
            if (en) begin
                if (pos == PERIOD - 1)
                    for (int n = 0; n < NUM_CH; n++)
                        act_m[n] = ramp ? ramp_toward(act_m[n], tgt_m[n]) : tgt_m[n];
                pos = (pos + 1) % PERIOD;
            end else begin
                pos = 0;
            end
            if (wr && ch < NUM_CH) tgt_m[ch] = (duty > PERIOD) ? PERIOD : duty;
            if (!en && !ramp)
                for (int n = 0; n < NUM_CH; n++) act_m[n] = tgt_m[n];
        end
        e.settled = 1'b1;
        for (int n = 0; n < NUM_CH; n++) if (act_m[n] != tgt_m[n]) e.settled = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic cyc(bit rst, bit wr, int ch, int duty);
        @(negedge clk);
        i_reset   = rst;
        i_en      = en_v;
        i_ramp_en = ramp_v;
        i_wr_en   = wr;
        i_wr_ch   = WR_W'(ch);
        i_wr_duty = CNT_W'(duty);
        model_step(rst, en_v, ramp_v, wr, ch, duty);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr(int ch, int duty);
        cyc(1'b0, 1'b1, ch, duty);
    endtask

    // Advance until the next cycle driven will sit at period offset p.
    task automatic run_to(int p);
        for (int i = 0; i < PERIOD + 1 && pos != p; i++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_pwm !== e.pwm) begin
                    errors++;
                    $display("FAIL pwm t=%0t got %b exp %b", $time, o_pwm, e.pwm);
                end
                checks++;
                if (o_period_start !== e.ps) begin
                    errors++;
                    $display("FAIL period_start t=%0t got %b exp %b", $time, o_period_start, e.ps);
                end
                checks++;
                if (o_settled !== e.settled) begin
                    errors++;
                    $display("FAIL settled t=%0t got %b exp %b", $time, o_settled, e.settled);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got timeout exp finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < NUM_CH; n++) begin
            tgt_m[n] = 0;
            act_m[n] = 0;
        end
        // Reset, then program ch1 while idle and enable.
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 2, 700);
        idle(3);
        wr(1, 300);
        en_v = 1'b1;
        idle(2100);

        // Extremes and clamp.
        wr(0, 0);
        wr(4, 1000);
        wr(3, 1023);
        idle(2100);

        // Mid-period update and a write in the boundary cycle.
        wr(2, 400);
        run_to(0);
        idle(PERIOD);
        run_to(100);
        wr(2, 600);
        run_to(PERIOD - 1);
        wr(2, 250);
        idle(2 * PERIOD + 5);

        // Ramp up to 95 and back to 0 on ch1.
        wr(1, 0);
        idle(PERIOD + 5);
        ramp_v = 1'b1;
        wr(1, 95);
        idle(11 * PERIOD);
        wr(1, 0);
        idle(11 * PERIOD);

        // Out-of-range channel writes.
        wr(5, 500);
        wr(7, 500);
        idle(PERIOD + 5);

        // Reset mid-period with channels active, then keep running.
        ramp_v = 1'b0;
        run_to(500);
        cyc(1'b1, 1'b1, 0, 800);
        idle(PERIOD + 10);

        // Randomised segments: writes, ramp and enable toggles.
        for (int k = 0; k < 30; k++) begin
            int len;
            if ($urandom_range(0, 7) == 0) en_v = ~en_v;
            if ($urandom_range(0, 3) == 0) ramp_v = ~ramp_v;
            len = $urandom_range(20, 700);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) < 2)
                    wr($urandom_range(0, 7), $urandom_range(0, 1023));
                else
                    idle(1);
            end
        end
        en_v = 1'b1;
        idle(2 * PERIOD + 5);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator that succeeds the fixed-threshold light comparator. It owns its own period counter and gives each of NUM_CH channels a runtime-programmable duty. Duty updates are double-buffered so they take effect only on a period boundary, and an optional ramp mode moves each channel toward its target by a fixed step per period, for smooth dimming. It sits between the control/register logic and the LED drivers.

## Interface
- CNT_W, 10: counter and duty width; requires 2^CNT_W > PERIOD.
- PERIOD, 1000: PWM period in clock cycles; counter range 0..PERIOD-1.
- NUM_CH, 5: number of channels.
- RAMP_STEP, 10: maximum duty change per period in ramp mode; must be ≥1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  run enable.
- i_ramp_en  in  1  1 = ramp active duty toward target; 0 = load target directly.
- i_wr_en  in  1  target-duty write strobe.
- i_wr_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write.
- i_wr_duty  in  CNT_W  new target duty, in cycles high per period.
- o_pwm  out  NUM_CH  registered PWM outputs; bit n = channel n.
- o_period_start  out  1  one-cycle pulse aligned with the first o_pwm cycle of each period.
- o_settled  out  1  high when every channel's active duty equals its target.

## Operation
- Counter cnt:
  - i_en=1: increments, wrapping from PERIOD-1 to 0.
  - i_en=0: cnt<=0.
- Boundary = cycle where i_en=1 and cnt==PERIOD-1.
- Target registers tgt[n]:
  - Written when i_wr_en=1 and i_wr_ch<NUM_CH.
  - Writes with i_wr_ch≥NUM_CH are ignored.
  - Values above PERIOD are clamped to PERIOD on write.
- Active registers act[n] are the duty values used for comparison.
- At a boundary:
  - i_ramp_en=0: act[n]<=tgt[n].
  - i_ramp_en=1: act[n] moves toward tgt[n] by min(RAMP_STEP, |tgt−act|). No overshoot; no change when equal.
- A write in the boundary cycle is not seen by that boundary's update. The boundary uses the old tgt; the new value applies at the next boundary.
- While i_en=0:
  - i_ramp_en=0: act[n] tracks tgt[n] every cycle, so enabling starts at the current targets.
  - i_ramp_en=1: act[n] holds.
- Compare: o_pwm[n] <= i_en & (cnt < act[n]).
  - act=0 gives constant low.
  - act=PERIOD gives constant high.
- o_period_start <= i_en & (cnt==0).
- o_settled = AND over n of (act[n]==tgt[n]), combinational from registers.
- Arithmetic: all comparisons unsigned at CNT_W bits. The ramp difference is computed at CNT_W+1 bits to avoid wrap.

## Timing
- Reset values:
  - cnt=0; tgt[n]=0; act[n]=0.
  - o_pwm=0; o_period_start=0; o_settled=1.
- Reset has priority over i_en and writes. A write in the reset cycle is lost.
- Reset mid-period: all state takes reset values at the next edge. o_pwm is low from the following cycle.
- Output latency: o_pwm and o_period_start are one cycle after the cnt value they are derived from.
- A period of o_pwm[n] is high for exactly act[n] consecutive cycles, starting with the o_period_start cycle.
- Target-write to output latency, i_en=1 and i_ramp_en=0: takes effect in the period after the next boundary; worst case PERIOD+1 cycles.
- i_en deassert: o_pwm and o_period_start go low one cycle later. On re-enable, the first o_period_start is one cycle after i_en rises.
- Ramp convergence: ceil(|tgt−act| / RAMP_STEP) boundaries.

## Test plan
- Reset with i_en=0, write ch1=300, then i_en=1 -> o_pwm[1] high for 300 cycles and low for 700, repeating every 1000 cycles; o_period_start pulses every 1000 cycles on the first high cycle; all other channels stay low.
- Write ch0=0, ch4=1000, ch3=1023 -> ch0 never high; ch4 and ch3 constantly high (ch3 clamped to 1000); o_settled=1 after the boundary.
- Mid-period update: ch2 running at 400, write 600 when cnt=100 -> current period is 400 high, next period 600 high; a write issued exactly at cnt=999 applies one period later.
- Ramp: i_ramp_en=1, act=0, write tgt=95 to ch1 -> successive periods high for 10, 20, ..., 90, 95 cycles; o_settled rises after the 10th boundary. Then write 0 -> high counts step down 85, 75, ..., 5, 0.
- Write with i_wr_ch=5 (NUM_CH=5), value 500 -> no channel changes; o_settled unchanged.
- Assert i_reset for 1 cycle at cnt=500 with several channels active -> o_pwm=0 next cycle; tgt and act cleared; after reset with i_en=1, o_period_start pulses 1 cycle later and all outputs stay low.
